// File: rtl/match_pe_scheduler.sv
// -----------------------------------------------------------------------------
// match_pe_scheduler
//
// Feeds match requests into a single match_pe_pipeline and owns that pipeline's
// scoreboard. Each accepted request takes one scoreboard entry and is issued as
// PE-width compare chunks. While a chunk matches completely, the entry is issued
// again at the next offset. The accumulated length saturates at MAX_MATCH_LEN.
// Results retire strictly in request-acceptance order through a small FIFO of
// entry indices.
//
// Entry life cycle: FREE -> INFLIGHT -> (EXTEND -> INFLIGHT)* -> DONE -> FREE
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 request in (valid/ready), head and history address
//   pe_valid/idx/last/    registered single-cycle issue into the pipeline
//   pe_head/history_addr
//   pe_o_*                pipeline result: valid, echoed last, idx, chunk length
//   rsp_*                 in-order retired result (valid/ready), total length and
//                         the request's original history address
//   busy                  at least one entry is not FREE
//
// Optional build macro: MATCH_SCHED_PERF_EN
//   Adds perf_issue_cnt, perf_ext_cnt and perf_retire_cnt (32-bit, wrapping).
//   They count issue pulses, EXTEND transitions and rsp handshakes.
// -----------------------------------------------------------------------------
module match_pe_scheduler #(
    parameter int SCOREBOARD_ENTRY_INDEX = 2,
    parameter int ADDR_W                 = 32,
    parameter int PE_WIDTH_LOG2          = 4,
    parameter int MAX_MATCH_LEN          = 64,
    parameter int LEN_W                  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_W-1:0]                 req_head_addr,
    input  logic [ADDR_W-1:0]                 req_history_addr,
    output logic                              pe_valid,
    output logic [SCOREBOARD_ENTRY_INDEX-1:0] pe_idx,
    output logic                              pe_last,
    output logic [ADDR_W-1:0]                 pe_head_addr,
    output logic [ADDR_W-1:0]                 pe_history_addr,
    input  logic                              pe_o_valid,
    input  logic                              pe_o_last,
    input  logic [SCOREBOARD_ENTRY_INDEX-1:0] pe_o_idx,
    input  logic [PE_WIDTH_LOG2:0]            pe_o_match_len,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [LEN_W-1:0]                  rsp_match_len,
    output logic [ADDR_W-1:0]                 rsp_history_addr,
    output logic                              busy
`ifdef MATCH_SCHED_PERF_EN
    ,
    output logic [31:0]                       perf_issue_cnt,
    output logic [31:0]                       perf_ext_cnt,
    output logic [31:0]                       perf_retire_cnt
`endif
);

    localparam int IDX_W = SCOREBOARD_ENTRY_INDEX;
    localparam int E     = 1 << IDX_W;
    localparam int CNT_W = IDX_W + 1;
    // One spare bit so acc_len + chunk (or + PW) never wraps before saturation.
    localparam int SUM_W = LEN_W + 1;

    localparam logic [SUM_W-1:0] MAX_LEN_S = SUM_W'(MAX_MATCH_LEN);
    localparam logic [SUM_W-1:0] PW_S      = SUM_W'(1 << PE_WIDTH_LOG2);

    localparam logic [1:0] ST_FREE     = 2'd0;
    localparam logic [1:0] ST_INFLIGHT = 2'd1;
    localparam logic [1:0] ST_EXTEND   = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Scoreboard entries
    logic [1:0]        state_q [E];
    logic [1:0]        state_d [E];
    logic [ADDR_W-1:0] head_q  [E];
    logic [ADDR_W-1:0] head_d  [E];
    logic [ADDR_W-1:0] hist_q  [E];
    logic [ADDR_W-1:0] hist_d  [E];
    logic [LEN_W-1:0]  acc_q   [E];
    logic [LEN_W-1:0]  acc_d   [E];

    // Order queue: entry indices in acceptance order
    logic [IDX_W-1:0]  order_q [E];
    logic [IDX_W-1:0]  order_d [E];
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Holds req_ready low until the first edge after reset is released.
    logic              ready_en_q, ready_en_d;

    // Registered outputs
    logic              pe_valid_q, pe_valid_d;
    logic [IDX_W-1:0]  pe_idx_q, pe_idx_d;
    logic              pe_last_q, pe_last_d;
    logic [ADDR_W-1:0] pe_head_q, pe_head_d;
    logic [ADDR_W-1:0] pe_hist_q, pe_hist_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [LEN_W-1:0]  rsp_len_q, rsp_len_d;
    logic [ADDR_W-1:0] rsp_hist_q, rsp_hist_d;

    // Scan results
    logic              any_free, any_ext, any_busy;
    logic [IDX_W-1:0]  free_idx, ext_idx;

    // Per-cycle events
    logic              req_fire, rsp_fire, issue_fire, ext_fire;
    logic [IDX_W-1:0]  issue_idx;
    logic [ADDR_W-1:0] issue_head, issue_hist;
    logic [LEN_W-1:0]  issue_acc;
    logic [SUM_W-1:0]  res_sum;
    logic [IDX_W-1:0]  head_ent, next_head_ent;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        any_free = 1'b0;
        any_ext  = 1'b0;
        any_busy = 1'b0;
        free_idx = '0;
        ext_idx  = '0;
        // Scan downward so the lowest matching index is the last one written.
        for (int i = E - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                any_busy = 1'b1;
            end
            if (state_q[i] == ST_EXTEND) begin
                any_ext = 1'b1;
                ext_idx = IDX_W'(i);
            end
        end
    end

    // A pending extension always beats a new request, so acceptance is shut off
    // while any entry waits in EXTEND.
    assign req_ready = ready_en_q && any_free && !any_ext;
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid_q && rsp_ready;
    assign head_ent  = order_q[rd_ptr_q];

    // NOTE: next-state logic uses blocking '=' in always_comb; only the clocked block uses '<='.
    always_comb begin
        for (int i = 0; i < E; i++) begin
            state_d[i] = state_q[i];
            head_d[i]  = head_q[i];
            hist_d[i]  = hist_q[i];
            acc_d[i]   = acc_q[i];
            order_d[i] = order_q[i];
        end
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        ready_en_d    = 1'b1;
        pe_valid_d    = 1'b0;
        pe_idx_d      = pe_idx_q;
        pe_last_d     = pe_last_q;
        pe_head_d     = pe_head_q;
        pe_hist_d     = pe_hist_q;
        rsp_valid_d   = 1'b0;
        rsp_len_d     = rsp_len_q;
        rsp_hist_d    = rsp_hist_q;
        res_sum       = '0;
        ext_fire      = 1'b0;
        issue_fire    = 1'b0;
        issue_idx     = '0;
        issue_head    = '0;
        issue_hist    = '0;
        issue_acc     = '0;
        next_head_ent = '0;

        // Retire: the head entry is DONE whenever rsp_valid_q is set.
        if (rsp_fire) begin
            state_d[head_ent] = ST_FREE;
            rd_ptr_d          = rd_ptr_q + IDX_W'(1);
        end

        // Result: only an INFLIGHT entry accepts it; others drop it silently.
        if (pe_o_valid && (state_q[pe_o_idx] == ST_INFLIGHT)) begin
            res_sum = {1'b0, acc_q[pe_o_idx]} + SUM_W'(pe_o_match_len);
            if (res_sum > MAX_LEN_S) begin
                res_sum = MAX_LEN_S;
            end
            acc_d[pe_o_idx] = res_sum[LEN_W-1:0];
            if ((SUM_W'(pe_o_match_len) == PW_S) && !pe_o_last && (res_sum < MAX_LEN_S)) begin
                state_d[pe_o_idx] = ST_EXTEND;
                ext_fire          = 1'b1;
            end else begin
                state_d[pe_o_idx] = ST_DONE;
            end
        end

        // Issue: re-issue an extension, else start a fresh request at offset 0.
        // The issued entry is EXTEND or FREE, so it never collides with the
        // result (INFLIGHT) or retire (DONE) entry above.
        if (any_ext) begin
            issue_fire = 1'b1;
            issue_idx  = ext_idx;
            issue_head = head_q[ext_idx];
            issue_hist = hist_q[ext_idx];
            issue_acc  = acc_q[ext_idx];
        end else if (req_fire) begin
            issue_fire        = 1'b1;
            issue_idx         = free_idx;
            issue_head        = req_head_addr;
            issue_hist        = req_history_addr;
            head_d[free_idx]  = req_head_addr;
            hist_d[free_idx]  = req_history_addr;
            acc_d[free_idx]   = '0;
            order_d[wr_ptr_q] = free_idx;
            wr_ptr_d          = wr_ptr_q + IDX_W'(1);
        end

        if (issue_fire) begin
            state_d[issue_idx] = ST_INFLIGHT;
            pe_valid_d         = 1'b1;
            pe_idx_d           = issue_idx;
            pe_head_d          = issue_head + ADDR_W'(issue_acc);
            pe_hist_d          = issue_hist + ADDR_W'(issue_acc);
            pe_last_d          = ({1'b0, issue_acc} + PW_S) >= MAX_LEN_S;
        end

        // rsp_valid follows the head entry's next state, so it rises the cycle
        // after the entry turns DONE and drops right after its handshake.
        next_head_ent = order_d[rd_ptr_d];
        if ((cnt_d != '0) && (state_d[next_head_ent] == ST_DONE)) begin
            rsp_valid_d = 1'b1;
            rsp_len_d   = acc_d[next_head_ent];
            rsp_hist_d  = hist_d[next_head_ent];
        end
    end

    // Queue occupancy equals the number of non-FREE entries, so pushes never
    // find the queue full.
    assign cnt_d = cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    // NOTE: the scoreboard is only E entries deep, so its storage is reset along with the control state; every output is X-free straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < E; i++) begin
                state_q[i] <= ST_FREE;
                head_q[i]  <= '0;
                hist_q[i]  <= '0;
                acc_q[i]   <= '0;
                order_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            ready_en_q  <= 1'b0;
            pe_valid_q  <= 1'b0;
            pe_idx_q    <= '0;
            pe_last_q   <= 1'b0;
            pe_head_q   <= '0;
            pe_hist_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_len_q   <= '0;
            rsp_hist_q  <= '0;
        end else begin
            for (int i = 0; i < E; i++) begin
                state_q[i] <= state_d[i];
                head_q[i]  <= head_d[i];
                hist_q[i]  <= hist_d[i];
                acc_q[i]   <= acc_d[i];
                order_q[i] <= order_d[i];
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            ready_en_q  <= ready_en_d;
            pe_valid_q  <= pe_valid_d;
            pe_idx_q    <= pe_idx_d;
            pe_last_q   <= pe_last_d;
            pe_head_q   <= pe_head_d;
            pe_hist_q   <= pe_hist_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_len_q   <= rsp_len_d;
            rsp_hist_q  <= rsp_hist_d;
        end
    end

    assign pe_valid         = pe_valid_q;
    assign pe_idx           = pe_idx_q;
    assign pe_last          = pe_last_q;
    assign pe_head_addr     = pe_head_q;
    assign pe_history_addr  = pe_hist_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_match_len    = rsp_len_q;
    assign rsp_history_addr = rsp_hist_q;
    assign busy             = any_busy;

`ifdef MATCH_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d;
    logic [31:0] perf_ext_cnt_q, perf_ext_cnt_d;
    logic [31:0] perf_retire_cnt_q, perf_retire_cnt_d;

    always_comb begin
        perf_issue_cnt_d  = perf_issue_cnt_q + 32'(issue_fire);
        perf_ext_cnt_d    = perf_ext_cnt_q + 32'(ext_fire);
        perf_retire_cnt_d = perf_retire_cnt_q + 32'(rsp_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt_q  <= '0;
            perf_ext_cnt_q    <= '0;
            perf_retire_cnt_q <= '0;
        end else begin
            perf_issue_cnt_q  <= perf_issue_cnt_d;
            perf_ext_cnt_q    <= perf_ext_cnt_d;
            perf_retire_cnt_q <= perf_retire_cnt_d;
        end
    end

    assign perf_issue_cnt  = perf_issue_cnt_q;
    assign perf_ext_cnt    = perf_ext_cnt_q;
    assign perf_retire_cnt = perf_retire_cnt_q;
`endif

endmodule

// File: tb/tb_match_pe_scheduler.sv
// -----------------------------------------------------------------------------
// tb_match_pe_scheduler
//
// Directed bench for match_pe_scheduler that also has a randomized phase. The
// bench plays the role of the match PE pipeline and picks each chunk's returned
// length. The reference model tracks every request's base addresses and its
// accumulated length, and keeps results in acceptance order. Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_match_pe_scheduler;

    localparam int IDX_W  = 2;
    localparam int E      = 4;
    localparam int ADDR_W = 32;
    localparam int PW     = 16;
    localparam int MAXL   = 64;
    localparam int LEN_W  = 8;
    localparam int LIMIT  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_head_addr = '0;
    logic [ADDR_W-1:0] req_history_addr = '0;
    logic              pe_valid;
    logic [IDX_W-1:0]  pe_idx;
    logic              pe_last;
    logic [ADDR_W-1:0] pe_head_addr;
    logic [ADDR_W-1:0] pe_history_addr;
    logic              pe_o_valid = 1'b0;
    logic              pe_o_last = 1'b0;
    logic [IDX_W-1:0]  pe_o_idx = '0;
    logic [4:0]        pe_o_match_len = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [LEN_W-1:0]  rsp_match_len;
    logic [ADDR_W-1:0] rsp_history_addr;
    logic              busy;

    match_pe_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_head_addr    (req_head_addr),
        .req_history_addr (req_history_addr),
        .pe_valid         (pe_valid),
        .pe_idx           (pe_idx),
        .pe_last          (pe_last),
        .pe_head_addr     (pe_head_addr),
        .pe_history_addr  (pe_history_addr),
        .pe_o_valid       (pe_o_valid),
        .pe_o_last        (pe_o_last),
        .pe_o_idx         (pe_o_idx),
        .pe_o_match_len   (pe_o_match_len),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_match_len    (rsp_match_len),
        .rsp_history_addr (rsp_history_addr),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state for the randomized phase
    logic [ADDR_W-1:0] m_head [E];
    logic [ADDR_W-1:0] m_hist [E];
    int                m_acc  [E];
    bit                m_fly  [E];
    int                n_req, pending, j, len, seen;
    bit                lst;
    logic [LEN_W-1:0]  bp_len;
    logic [ADDR_W-1:0] bp_hist;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request and check the issue it produces in the following cycle.
    task automatic do_req(input string tag, input logic [ADDR_W-1:0] head,
                          input logic [ADDR_W-1:0] hist, input int exp_idx);
        int n = 0;
        req_valid        = 1'b1;
        req_head_addr    = head;
        req_history_addr = hist;
        while (req_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_pe_valid"}, pe_valid, 1'b1);
        check({tag, "_pe_idx"}, pe_idx, exp_idx);
        check({tag, "_pe_head"}, pe_head_addr, head);
        check({tag, "_pe_hist"}, pe_history_addr, hist);
        check({tag, "_pe_last"}, pe_last, 1'b0);
    endtask

    // Wait (bounded) for an extension issue and check its fields.
    task automatic wait_issue(input string tag, input int exp_idx, input logic [ADDR_W-1:0] head,
                              input logic [ADDR_W-1:0] hist, input bit last);
        int n = 0;
        while (pe_valid !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_pe_valid"}, pe_valid, 1'b1);
        if (pe_valid === 1'b1) begin
            check({tag, "_pe_idx"}, pe_idx, exp_idx);
            check({tag, "_pe_head"}, pe_head_addr, head);
            check({tag, "_pe_hist"}, pe_history_addr, hist);
            check({tag, "_pe_last"}, pe_last, last);
        end
    endtask

    // One-cycle pipeline result.
    task automatic return_result(input int idx, input int l, input bit last);
        pe_o_valid     = 1'b1;
        pe_o_idx       = IDX_W'(idx);
        pe_o_match_len = 5'(l);
        pe_o_last      = last;
        @(negedge clk);
        pe_o_valid = 1'b0;
        pe_o_last  = 1'b0;
    endtask

    // Accept one response and compare it; returns one cycle after the handshake.
    task automatic expect_rsp(input string tag, input int exp_len, input logic [ADDR_W-1:0] exp_hist);
        int n = 0;
        rsp_ready = 1'b1;
        while (rsp_valid !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        check({tag, "_rsp_len"}, rsp_match_len, exp_len);
        check({tag, "_rsp_hist"}, rsp_history_addr, exp_hist);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_pe_valid", pe_valid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_len", rsp_match_len, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_pe_valid", pe_valid, 1'b0);

        // ---------------- single request ----------------
        do_req("single", 32'h100, 32'h40, 0);
        check("single_busy", busy, 1'b1);
        return_result(0, 5, 1'b0);
        expect_rsp("single", 5, 32'h40);
        check("single_idle", busy, 1'b0);

        // ---------------- extension 16,16,7 ----------------
        do_req("ext", 32'h200, 32'h80, 0);
        return_result(0, 16, 1'b0);
        wait_issue("ext1", 0, 32'h210, 32'h90, 1'b0);
        return_result(0, 16, 1'b0);
        wait_issue("ext2", 0, 32'h220, 32'ha0, 1'b0);
        return_result(0, 7, 1'b0);
        expect_rsp("ext", 39, 32'h80);

        // ---------------- cap at MAX_MATCH_LEN ----------------
        do_req("cap", 32'h300, 32'h10, 0);
        return_result(0, 16, 1'b0);
        wait_issue("cap1", 0, 32'h310, 32'h20, 1'b0);
        return_result(0, 16, 1'b0);
        wait_issue("cap2", 0, 32'h320, 32'h30, 1'b0);
        return_result(0, 16, 1'b0);
        wait_issue("cap3", 0, 32'h330, 32'h40, 1'b1);
        return_result(0, 16, 1'b1);
        seen = 0;
        repeat (6) begin
            if (pe_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check("cap_no_5th_issue", seen, 0);
        expect_rsp("cap", 64, 32'h10);

        // ---------------- full scoreboard ----------------
        for (int k = 0; k < E; k++) begin
            do_req("full", 32'h1000 + 32'(k) * 32'h100, 32'h2000 + 32'(k) * 32'h10, k);
        end
        req_valid        = 1'b1;
        req_head_addr    = 32'h5000;
        req_history_addr = 32'h6000;
        check("full_ready0", req_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        @(negedge clk);
        check("full_ready1", req_ready, 1'b0);
        return_result(0, 2, 1'b0);
        check("full_ready_done", req_ready, 1'b0);
        expect_rsp("full0", 2, 32'h2000);
        check("full_ready_after_rsp", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        check("full_realloc_valid", pe_valid, 1'b1);
        check("full_realloc_idx", pe_idx, 0);
        check("full_realloc_head", pe_head_addr, 32'h5000);
        return_result(1, 1, 1'b0);
        return_result(2, 2, 1'b0);
        return_result(3, 3, 1'b0);
        return_result(0, 4, 1'b0);
        expect_rsp("full1", 1, 32'h2010);
        expect_rsp("full2", 2, 32'h2020);
        expect_rsp("full3", 3, 32'h2030);
        expect_rsp("full4", 4, 32'h6000);

        // ---------------- ordering ----------------
        do_req("ordA", 32'h400, 32'h11, 0);
        do_req("ordB", 32'h480, 32'h22, 1);
        return_result(1, 3, 1'b0);
        rsp_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            if (rsp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check("ord_held", seen, 0);
        return_result(0, 9, 1'b0);
        expect_rsp("ord_first", 9, 32'h11);
        expect_rsp("ord_second", 3, 32'h22);

        // ---------------- response backpressure ----------------
        do_req("bp", 32'h500, 32'h77, 0);
        return_result(0, 4, 1'b0);
        seen = 0;
        while (rsp_valid !== 1'b1 && seen < LIMIT) begin
            @(negedge clk);
            seen++;
        end
        bp_len  = 8'd4;
        bp_hist = 32'h77;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_len", rsp_match_len, bp_len);
            check("bp_hist", rsp_history_addr, bp_hist);
            @(negedge clk);
        end
        expect_rsp("bp", 4, 32'h77);

        // ---------------- reset mid-extension ----------------
        do_req("mid", 32'h600, 32'h88, 0);
        return_result(0, 16, 1'b0);
        wait_issue("mid_ext", 0, 32'h610, 32'h98, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_pe_valid", pe_valid, 1'b0);
        check("async_rsp_valid", rsp_valid, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_req_ready", req_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_req_ready", req_ready, 1'b1);
        do_req("fresh", 32'h700, 32'h99, 0);
        return_result(0, 6, 1'b0);
        expect_rsp("fresh", 6, 32'h99);

        // ---------------- randomized rounds vs. reference model ----------------
        for (int r = 0; r < 12; r++) begin
            n_req = $urandom_range(1, E);
            for (int k = 0; k < n_req; k++) begin
                m_head[k] = $urandom;
                m_hist[k] = $urandom;
                m_acc[k]  = 0;
                m_fly[k]  = 1'b1;
                do_req("rnd_req", m_head[k], m_hist[k], k);
            end
            pending = n_req;
            while (pending > 0) begin
                j = $urandom_range(0, n_req - 1);
                while (!m_fly[j]) j = (j + 1) % n_req;
                len = ($urandom_range(0, 1) == 1) ? PW : $urandom_range(0, PW - 1);
                lst = (m_acc[j] + PW >= MAXL);
                return_result(j, len, lst);
                m_acc[j] = (m_acc[j] + len > MAXL) ? MAXL : m_acc[j] + len;
                if (len == PW && !lst && m_acc[j] < MAXL) begin
                    wait_issue("rnd_ext", j, m_head[j] + 32'(m_acc[j]),
                               m_hist[j] + 32'(m_acc[j]), (m_acc[j] + PW >= MAXL));
                end else begin
                    m_fly[j] = 1'b0;
                    pending--;
                end
            end
            for (int k = 0; k < n_req; k++) begin
                expect_rsp("rnd", m_acc[k], m_hist[k]);
            end
            check("rnd_idle", busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
